// File: rtl/shift_cmp_arbiter.sv
// ---------------------------------------------------------------------------
// shift_cmp_arbiter
//
// Round-robin scheduler that shares one shift/compare datapath among NREQ
// requesters. A granted requester's operand is latched and handed to the
// datapath with a one-cycle start pulse. The datapath's done is then awaited
// under a watchdog. The result, tagged with the requester id, goes back with
// a one-cycle ack / result_valid pulse.
//
// Optional feature macro: SCARB_FIXED_PRIO_EN
//   defined   -> fixed priority, lowest asserted req index always wins
//   undefined -> rotating priority starting at the round-robin pointer
//
// Ports:
//   clock        in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   req          in   per-requester request level, held until its ack
//   req_data     in   operands, requester i at bits [i*DW +: DW]
//   gnt          out  one-hot grant, high from ISSUE through RESP
//   ack          out  one-cycle completion pulse to the granted requester
//   dp_start     out  one-cycle start pulse to the datapath controller
//   dp_operand   out  latched operand, stable from ISSUE through RESP
//   dp_done      in   datapath completion (level or pulse)
//   dp_result    in   datapath result, valid while dp_done=1
//   result       out  captured result (zero after a watchdog abort)
//   result_id    out  id of the requester owning result
//   result_valid out  one-cycle pulse, coincident with ack
//   timeout_err  out  one-cycle pulse on watchdog abort
//   busy         out  high in every state except IDLE
// ---------------------------------------------------------------------------
module shift_cmp_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 31
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic                 dp_start,
  output logic [DW-1:0]        dp_operand,
  input  logic                 dp_done,
  input  logic [DW-1:0]        dp_result,
  output logic [DW-1:0]        result,
  output logic [IDW-1:0]       result_id,
  output logic                 result_valid,
  output logic                 timeout_err,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [7:0]     TIMEOUT_L = 8'(TIMEOUT);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [IDW-1:0]   r_id;
  logic [DW-1:0]    r_operand;
  logic [7:0]       r_timer;
  logic [DW-1:0]    r_result;
  logic [IDW-1:0]   r_resultId;
  logic [IDW-1:0]   w_winner;
  logic             w_found;
  logic             w_reqAny;
  logic             w_timerExpire;
  logic [NREQ-1:0]  w_idOneHot;
`ifndef SCARB_FIXED_PRIO_EN
  logic [IDW-1:0]   r_rrPtr;
`endif

  assign w_reqAny = |req;

  // The timer holds the number of WAIT cycles already completed, so the
  // current WAIT cycle is number r_timer+1. The watchdog fires on the cycle
  // whose number equals TIMEOUT.
  assign w_timerExpire = ((r_timer + 8'd1) == TIMEOUT_L);

  assign w_idOneHot = {{(NREQ-1){1'b0}}, 1'b1} << r_id;

  // Winner selection. The scan index is always reduced modulo NREQ, so an
  // id at or above NREQ can never be picked.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef SCARB_FIXED_PRIO_EN
      if (!w_found && req[k]) begin
        w_found  = 1'b1;
        w_winner = IDW'(k);
      end
`else
      if (!w_found && req[(int'(r_rrPtr) + k) % NREQ]) begin
        w_found  = 1'b1;
        w_winner = IDW'((int'(r_rrPtr) + k) % NREQ);
      end
`endif
    end
  end

  // State register for the IDLE -> ISSUE -> WAIT -> RESP sequence.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and the single-cycle strobes. A done that arrives in the same
  // cycle as watchdog expiry takes precedence, so no error is flagged then.
  always_comb begin
    w_nextState  = r_state;
    dp_start     = 1'b0;
    result_valid = 1'b0;
    timeout_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_reqAny) begin
          w_nextState = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        dp_start    = 1'b1;
        w_nextState = ST_WAIT;
      end
      ST_WAIT: begin
        if (dp_done) begin
          w_nextState = ST_RESP;
        end else if (w_timerExpire) begin
          timeout_err = 1'b1;
          w_nextState = ST_RESP;
        end
      end
      ST_RESP: begin
        result_valid = 1'b1;
        w_nextState  = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Operand/id latch, watchdog timer and result capture. The id latched in
  // IDLE is copied into result_id when WAIT exits, which makes result_id
  // valid during RESP and keeps it stable until the next RESP. A done seen
  // during ISSUE is ignored because only WAIT looks at dp_done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_id       <= '0;
      r_operand  <= '0;
      r_timer    <= '0;
      r_result   <= '0;
      r_resultId <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_reqAny) begin
            r_id      <= w_winner;
            r_operand <= req_data[int'(w_winner)*DW +: DW];
          end
        end
        ST_ISSUE: begin
          r_timer <= '0;
        end
        ST_WAIT: begin
          if (dp_done) begin
            r_result   <= dp_result;
            r_resultId <= r_id;
          end else if (w_timerExpire) begin
            r_result   <= '0;
            r_resultId <= r_id;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifndef SCARB_FIXED_PRIO_EN
  // Rotating pointer. After a requester is served, it moves to the slot just
  // past that requester, so the requester just served has the lowest
  // priority in the next arbitration.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rrPtr <= '0;
    end else if (r_state == ST_RESP) begin
      r_rrPtr <= (r_id == LAST_ID) ? '0 : r_id + 1'b1;
    end
  end
`endif

  assign busy       = (r_state != ST_IDLE);
  assign gnt        = busy ? w_idOneHot : '0;
  assign ack        = result_valid ? w_idOneHot : '0;
  assign dp_operand = r_operand;
  assign result     = r_result;
  assign result_id  = r_resultId;

endmodule

// File: doc/shift_cmp_arbiter.md
Name: shift_cmp_arbiter

Overview:
Round-robin scheduler sharing the single shift/compare datapath (START/DONE-style controller plus shift register) among NREQ requesters. Accepts one operand per granted requester and issues a one-cycle start to the datapath. Waits for done, with a timeout watchdog, then returns the result tagged with the requester id.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 4, operand/result width in bits
IDW, 2, requester id width; must satisfy 2**IDW >= NREQ
TIMEOUT, 31, max cycles in WAIT before abort (1..255)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester request level; held until matching ack
req_data  in  NREQ*DW  operands, requester i at bits [i*DW +: DW]
gnt  out  NREQ  one-hot grant, high from ISSUE through RESP
ack  out  NREQ  one-cycle completion pulse to granted requester
dp_start  out  1  one-cycle start pulse to datapath controller
dp_operand  out  DW  latched operand, stable from ISSUE through RESP
dp_done  in  1  datapath completion (level or pulse)
dp_result  in  DW  datapath result, valid when dp_done=1
result  out  DW  captured result (zero on timeout)
result_id  out  IDW  id of requester owning result
result_valid  out  1  one-cycle pulse, coincident with ack
timeout_err  out  1  one-cycle pulse on watchdog abort
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, reset_n=0): state=IDLE, rr_ptr=0, timer=0. All outputs 0, including gnt, ack, dp_start, dp_operand, result, result_id, result_valid, timeout_err and busy. Reset mid-operation aborts silently: no ack, no result_valid.
- States:
  - IDLE: if |req, pick winner by rotating priority starting at rr_ptr (first set bit scanning rr_ptr, rr_ptr+1, ... mod NREQ). Latch id and req_data slice, then go to ISSUE. If req=0, stay in IDLE.
  - ISSUE: dp_start=1 for exactly this cycle; timer cleared; go to WAIT.
  - WAIT: if dp_done=1, capture dp_result into result and go to RESP. Otherwise timer increments. When timer reaches TIMEOUT with dp_done still 0, pulse timeout_err this cycle, set result=0, and go to RESP.
  - RESP: result_valid=1, ack[id]=1, result_id=id; rr_ptr <= (id+1) mod NREQ; go to IDLE.
- gnt[id]=1 in ISSUE, WAIT and RESP; all gnt bits are 0 in IDLE.
- req is sampled only in IDLE. Dropping req mid-operation has no effect: the operation completes and ack still pulses. New requests arriving mid-operation wait.
- Latency from req rising in IDLE to ack is 3 + N cycles, where N is the number of WAIT cycles (N>=1).
- Back-to-back operation: the cycle after RESP is IDLE, so arbitration happens again; there is a minimum of 1 idle cycle between operations.
- dp_done in ISSUE is ignored. dp_done and timer expiry in the same cycle: done wins and no timeout_err is raised.
- result and result_id hold their values until the next RESP.
- Out-of-range slots (id >= NREQ) are never granted.

Optional Feature:
SCARB_FIXED_PRIO_EN
- Defined: fixed priority; the lowest asserted req index always wins, and rr_ptr is neither used nor updated.
- Undefined (default): round-robin as described above.

Test Plan:
- Single request: NREQ=4, req=4'b0100, req_data slice2=4'hA; dp_done asserted 4 cycles after dp_start with dp_result=4'h5 -> gnt=4'b0100, dp_operand=4'hA, one dp_start pulse, then result=4'h5, result_id=2, ack=4'b0100 single pulse.
- Fairness: req=4'b1111 held throughout, done after 1 cycle each time -> grant order 0,1,2,3,0 with 1 IDLE cycle between operations.
- Timeout: TIMEOUT=31, dp_done never asserted -> timeout_err pulses on the 31st WAIT cycle, result=0, ack pulses, busy drops the next cycle.
- Request drop: req[1] deasserted 2 cycles into WAIT -> operation completes and ack[1] still pulses. Also drive dp_done together with timer==TIMEOUT -> no timeout_err.
- Reset mid-WAIT: reset_n=0 for 1 cycle -> all outputs 0 immediately with no ack; next request with req=4'b0010 is granted from rr_ptr=0.
- With SCARB_FIXED_PRIO_EN defined: req=4'b1010 held -> index 1 granted every time and index 3 never granted.
